// File: rtl/match_cnt_pkg.sv
// Shared types and default sizing for the match window counter.
package match_cnt_pkg;

    typedef enum logic {IDLE, RUN} mwc_state_t;

    localparam int unsigned MWC_CNT_W      = 8;
    localparam int unsigned MWC_WIN_W      = 16;
    localparam int unsigned MWC_WINDOW_LEN = 256;

endpackage

// File: rtl/sat_inc.sv
// Combinational saturating incrementer; o_sat flags an increment clipped at all-ones.
module sat_inc #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_in,
    input  logic         i_inc,
    output logic [W-1:0] o_out,
    output logic         o_sat
);

    logic w_at_max;

    always_comb begin
        w_at_max = (i_in == '1);
        o_sat    = w_at_max && i_inc;
        o_out    = o_sat ? i_in : i_in + W'(i_inc);
    end

endmodule

// File: rtl/match_window_counter.sv
// Counts detector match pulses over fixed windows and hands each window's
// count to a 1-deep valid/ready output register.
module match_window_counter
    import match_cnt_pkg::*;
#(
    parameter int unsigned CNT_W      = MWC_CNT_W,
    parameter int unsigned WIN_W      = MWC_WIN_W,
    parameter int unsigned WINDOW_LEN = MWC_WINDOW_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             z,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_sat,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             drop
);

    localparam logic [WIN_W-1:0] LAST_POS = WIN_W'(WINDOW_LEN - 1);

    mwc_state_t       r_state;
    logic [CNT_W-1:0] r_acc;
    logic             r_acc_sat;
    logic [WIN_W-1:0] r_win_pos;
    logic [CNT_W-1:0] r_cnt_data;
    logic             r_cnt_sat;
    logic             r_cnt_valid;
    logic             r_drop;

    logic [CNT_W-1:0] w_acc_next;
    logic             w_inc_sat;
    logic             w_close;
    logic             w_accept;

    // acc+z serves both the running count and the close-edge final value,
    // so the last cycle's match lands in the closing window.
    sat_inc #(.W(CNT_W)) u_acc_inc (
        .i_in  (r_acc),
        .i_inc (z),
        .o_out (w_acc_next),
        .o_sat (w_inc_sat)
    );

    assign w_close  = (r_state == RUN) && en && (r_win_pos == LAST_POS);
    assign w_accept = r_cnt_valid && cnt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_acc_sat   <= 1'b0;
            r_win_pos   <= '0;
            r_cnt_data  <= '0;
            r_cnt_sat   <= 1'b0;
            r_cnt_valid <= 1'b0;
            r_drop      <= 1'b0;
        end else if (clr) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_acc_sat   <= 1'b0;
            r_win_pos   <= '0;
            r_cnt_data  <= '0;
            r_cnt_sat   <= 1'b0;
            r_cnt_valid <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_accept) begin
                r_cnt_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_acc     <= '0;
                    r_acc_sat <= 1'b0;
                    r_win_pos <= '0;
                    if (en) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_state   <= IDLE;
                        r_acc     <= '0;
                        r_acc_sat <= 1'b0;
                        r_win_pos <= '0;
                    end else if (w_close) begin
                        r_acc     <= '0;
                        r_acc_sat <= 1'b0;
                        r_win_pos <= '0;
                        // A same-edge accept frees the register for the new result.
                        if (!r_cnt_valid || cnt_ready) begin
                            r_cnt_data  <= w_acc_next;
                            r_cnt_sat   <= r_acc_sat | w_inc_sat;
                            r_cnt_valid <= 1'b1;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end else begin
                        r_acc     <= w_acc_next;
                        r_acc_sat <= r_acc_sat | w_inc_sat;
                        r_win_pos <= r_win_pos + WIN_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cnt_data  = r_cnt_data;
    assign cnt_sat   = r_cnt_sat;
    assign cnt_valid = r_cnt_valid;
    assign drop      = r_drop;

endmodule

// File: tb/tb_match_window_counter.sv
// Scoreboard bench: an 8-bit and a 2-bit counter share stimulus, WINDOW_LEN=8.
module tb_match_window_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       z;
    logic       cnt_ready;

    logic [7:0] cnt_data;
    logic       cnt_sat;
    logic       cnt_valid;
    logic       drop;

    logic [1:0] s_data;
    logic       s_sat;
    logic       s_valid;
    logic       s_drop;

    typedef struct packed {
        logic [7:0] d8;
        logic       s8;
        logic [1:0] d2;
        logic       s2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_drop   = 0;
    int   n_drop_s = 0;

    always #5 clk = ~clk;

    match_window_counter #(.CNT_W(8), .WIN_W(16), .WINDOW_LEN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .z         (z),
        .cnt_data  (cnt_data),
        .cnt_sat   (cnt_sat),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .drop      (drop)
    );

    match_window_counter #(.CNT_W(2), .WIN_W(4), .WINDOW_LEN(8)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .z         (z),
        .cnt_data  (s_data),
        .cnt_sat   (s_sat),
        .cnt_valid (s_valid),
        .cnt_ready (cnt_ready),
        .drop      (s_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int n);
        exp_t e;
        e.d8 = 8'((n > 255) ? 255 : n);
        e.s8 = (n > 255);
        e.d2 = 2'((n > 3) ? 3 : n);
        e.s2 = (n > 3);
        return e;
    endfunction

    task automatic take();
        exp_t e;
        check("sb_nonempty", 32'(q.size() != 0), 1);
        if (q.size() == 0) return;
        e = q.pop_front();
        check("acc_data8", cnt_data, e.d8);
        check("acc_sat8", cnt_sat, e.s8);
        check("acc_valid2", s_valid, 1);
        check("acc_data2", s_data, e.d2);
        check("acc_sat2", s_sat, e.s2);
    endtask

    // Drive z for one cycle; accepted results are popped and compared before the edge.
    task automatic step(input logic zi);
        z = zi;
        #1;
        if (drop) n_drop++;
        if (s_drop) n_drop_s++;
        if (!rst && !clr && cnt_valid && cnt_ready) take();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_window(input logic [7:0] zp, input bit keep);
        if (keep) q.push_back(mk($countones(zp)));
        for (int i = 0; i < 8; i++) step(zp[i]);
    endtask

    task automatic go_idle();
        en = 1'b0;
        step(1'b0);
    endtask

    task automatic start_run();
        en = 1'b1;
        step(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1 (bench did not finish)");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] zp;
        int d0;
        int d0s;
        rst = 1'b1; en = 1'b0; clr = 1'b0; z = 1'b0; cnt_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", cnt_data, 0);
        check("rst_sat", cnt_sat, 0);
        check("rst_valid", cnt_valid, 0);
        check("rst_drop", drop, 0);
        check("rst_valid2", s_valid, 0);
        rst = 1'b0;

        // Async reset mid-window with a result pending.
        start_run();
        run_window(8'h05, 1);
        check("pend_valid", cnt_valid, 1);
        check("pend_data", cnt_data, 2);
        step(1); step(1); step(1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", cnt_valid, 0);
        check("arst_data", cnt_data, 0);
        check("arst_valid2", s_valid, 0);
        check("arst_data2", s_data, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cnt_ready = 1'b1;
        step(1);
        run_window(8'h30, 1);
        step(0);
        go_idle();

        // Basic count: matches on cycles 1, 3, 7.
        start_run();
        zp = 8'h8A;
        q.push_back(mk(3));
        for (int i = 0; i < 7; i++) step(zp[i]);
        check("basic_pre_valid", cnt_valid, 0);
        step(zp[7]);
        check("basic_valid", cnt_valid, 1);
        check("basic_data", cnt_data, 3);
        check("basic_sat", cnt_sat, 0);
        step(0);
        check("basic_valid_fall", cnt_valid, 0);
        go_idle();

        // Saturation on the 2-bit instance, then an unsaturated window.
        start_run();
        run_window(8'hFF, 1);
        run_window(8'h01, 1);
        step(0);
        go_idle();

        // Backpressure: second result dropped.
        start_run();
        cnt_ready = 1'b0;
        d0 = n_drop; d0s = n_drop_s;
        run_window(8'h03, 1);
        run_window(8'h1F, 0);
        check("bp_hold_data", cnt_data, 2);
        step(0);
        check("bp_drop_cnt", n_drop - d0, 1);
        check("bp_drop_cnt2", n_drop_s - d0s, 1);
        check("bp_still_valid", cnt_valid, 1);
        cnt_ready = 1'b1;
        step(0);
        check("bp_valid_fall", cnt_valid, 0);
        go_idle();

        // Accept on the closing edge.
        start_run();
        cnt_ready = 1'b0;
        run_window(8'h0F, 1);
        d0 = n_drop;
        zp = 8'h3F;
        q.push_back(mk(6));
        for (int i = 0; i < 7; i++) step(zp[i]);
        cnt_ready = 1'b1;
        step(zp[7]);
        cnt_ready = 1'b0;
        check("aoc_valid", cnt_valid, 1);
        check("aoc_data", cnt_data, 6);
        check("aoc_drop", drop, 0);
        step(0);
        cnt_ready = 1'b1;
        step(0);
        check("aoc_drop_cnt", n_drop - d0, 0);
        go_idle();

        // Abort at cycle 5, then a fresh window.
        cnt_ready = 1'b0;
        start_run();
        step(1); step(1); step(0); step(1); step(0);
        en = 1'b0;
        step(1);
        repeat (10) step(1);
        check("abort_no_valid", cnt_valid, 0);
        check("abort_no_valid2", s_valid, 0);
        start_run();
        cnt_ready = 1'b1;
        run_window(8'h81, 1);
        step(0);
        go_idle();

        // Clear with a pending result.
        start_run();
        cnt_ready = 1'b0;
        run_window(8'h1F, 1);
        check("clr_pend_valid", cnt_valid, 1);
        check("clr_pend_data", cnt_data, 5);
        clr = 1'b1;
        step(0);
        clr = 1'b0;
        q.delete();
        check("clr_valid", cnt_valid, 0);
        check("clr_data", cnt_data, 0);
        check("clr_sat", cnt_sat, 0);
        check("clr_valid2", s_valid, 0);
        step(0);
        cnt_ready = 1'b1;
        run_window(8'h02, 1);
        step(0);
        go_idle();

        check("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
